// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl - time-multiplexed hex 7-segment display driver.
//
// Cycles through N_DIGITS digits, dwelling PRESCALE clocks on each, and drives
// a one-hot anode select plus the hex-decoded segments of the active digit.
// Anode, segment and decimal-point outputs are registered (1-cycle latency
// relative to digit_sel_o and the sampled digits_i/dp_i).
//
// Ports
//   clck_i       system clock (posedge)
//   rst_i        synchronous reset, active-high
//   enable_i     1: scan and drive, 0: freeze scan and blank outputs
//   hold_i       1: freeze scan on current digit, keep driving it (beats enable_i)
//   digits_i     packed hex nibbles, digit k at [4k+3:4k], digit 0 = LSD
//   dp_i         per-digit decimal point, 1 = lit
//   digit_sel_o  current digit index
//   anode_o      one-hot anode drive, polarity from ANODE_ACT_LOW
//   seg_o        segments {g,f,e,d,c,b,a}, polarity from SEG_ACT_LOW
//   dp_o         decimal point, polarity from SEG_ACT_LOW
//   tick_o       1-cycle pulse in the cycle after the index advances
//
// Build option
//   SEG7_LZ_BLANK_EN  when defined, leading zeros (digits k>0 that are 0 with
//                     all higher digits 0) have their segments blanked.
//                     Anodes keep cycling and dp_o is still driven.

module seg7_scan_ctrl #(
  parameter int N_DIGITS      = 4,
  parameter int PRESCALE      = 50000,
  parameter int ANODE_ACT_LOW = 1,
  parameter int SEG_ACT_LOW   = 1,
  localparam int IDX_W        = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1
) (
  input  logic                  clck_i,
  input  logic                  rst_i,
  input  logic                  enable_i,
  input  logic                  hold_i,
  input  logic [4*N_DIGITS-1:0] digits_i,
  input  logic [N_DIGITS-1:0]   dp_i,
  output logic [IDX_W-1:0]      digit_sel_o,
  output logic [N_DIGITS-1:0]   anode_o,
  output logic [6:0]            seg_o,
  output logic                  dp_o,
  output logic                  tick_o
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  // XOR masks: an active-high value XOR the mask gives the pin level.
  // The mask itself is therefore the "all inactive" pin level.
  localparam logic [N_DIGITS-1:0] AN_OFF  = (ANODE_ACT_LOW != 0) ? {N_DIGITS{1'b1}} : {N_DIGITS{1'b0}};
  localparam logic [6:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic                DP_OFF  = (SEG_ACT_LOW != 0);

  localparam logic [PW-1:0]    PRE_LAST = PW'(PRESCALE - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_DIGITS - 1);

  logic [PW-1:0]       pre;
  logic [3:0]          nib;
  logic                dp_cur;
  logic                blank_cur;
  logic [N_DIGITS-1:0] hot;
  logic [6:0]          seg_hi;
  logic                scan;
  logic                drive;

  // Standard hex font, active-high {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'h3F;
      4'h1: hex7 = 7'h06;
      4'h2: hex7 = 7'h5B;
      4'h3: hex7 = 7'h4F;
      4'h4: hex7 = 7'h66;
      4'h5: hex7 = 7'h6D;
      4'h6: hex7 = 7'h7D;
      4'h7: hex7 = 7'h07;
      4'h8: hex7 = 7'h7F;
      4'h9: hex7 = 7'h6F;
      4'hA: hex7 = 7'h77;
      4'hB: hex7 = 7'h7C;
      4'hC: hex7 = 7'h39;
      4'hD: hex7 = 7'h5E;
      4'hE: hex7 = 7'h79;
      default: hex7 = 7'h71;
    endcase
  endfunction

`ifdef SEG7_LZ_BLANK_EN
  // blank[k]: digit k and every digit above it are zero. Digit 0 never blanks.
  logic [N_DIGITS-1:0] blank;
  logic                zero_above;
  always_comb begin
    blank      = '0;
    zero_above = 1'b1;
    for (int k = N_DIGITS - 1; k >= 1; k--) begin
      zero_above = zero_above & (digits_i[4*k +: 4] == 4'h0);
      blank[k]   = zero_above;
    end
  end
`endif

  // Select the active digit's nibble/dp and build the one-hot anode pattern.
  // A compare-per-digit mux avoids out-of-range indexing when N_DIGITS is not
  // a power of two.
  always_comb begin
    nib       = 4'h0;
    dp_cur    = 1'b0;
    blank_cur = 1'b0;
    hot       = '0;
    for (int k = 0; k < N_DIGITS; k++) begin
      if (digit_sel_o == IDX_W'(k)) begin
        nib    = digits_i[4*k +: 4];
        dp_cur = dp_i[k];
        hot[k] = 1'b1;
`ifdef SEG7_LZ_BLANK_EN
        blank_cur = blank[k];
`endif
      end
    end
  end

  assign seg_hi = blank_cur ? 7'h00 : hex7(nib);
  assign scan   = enable_i & ~hold_i;
  // Hold keeps the display lit even when enable_i is low.
  assign drive  = hold_i | enable_i;

  always_ff @(posedge clck_i) begin
    if (rst_i) begin
      pre         <= '0;
      digit_sel_o <= '0;
      tick_o      <= 1'b0;
      anode_o     <= AN_OFF;
      seg_o       <= SEG_OFF;
      dp_o        <= DP_OFF;
    end else begin
      tick_o <= 1'b0;
      if (scan) begin
        if (pre == PRE_LAST) begin
          pre    <= '0;
          tick_o <= 1'b1;
          digit_sel_o <= (digit_sel_o == IDX_LAST) ? '0 : digit_sel_o + IDX_W'(1);
        end else begin
          pre <= pre + PW'(1);
        end
      end
      // Output stage uses the pre-edge index and the inputs sampled now.
      if (drive) begin
        anode_o <= hot ^ AN_OFF;
        seg_o   <= seg_hi ^ SEG_OFF;
        dp_o    <= dp_cur ^ DP_OFF;
      end else begin
        anode_o <= AN_OFF;
        seg_o   <= SEG_OFF;
        dp_o    <= DP_OFF;
      end
    end
  end

endmodule
